// File: rtl/blink_sched_if.sv
// Request/grant bundle between status sources and the shared blink scheduler.
// A requester raises req_i with cnt_i/per_i valid and holds it until its done_o pulse;
// dropping req_i early while granted aborts the burst without a done pulse.
interface blink_sched_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int PER_W = 4
);
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*CNT_W-1:0] cnt_i;
  logic [N_REQ*PER_W-1:0] per_i;
  logic [N_REQ-1:0]       gnt_o;
  logic [N_REQ-1:0]       done_o;
  logic                   busy_o;
  logic                   led_o;
  logic                   tick_o;

  modport master (
    output req_i, cnt_i, per_i,
    input  gnt_o, done_o, busy_o, led_o, tick_o
  );

  modport slave (
    input  req_i, cnt_i, per_i,
    output gnt_o, done_o, busy_o, led_o, tick_o
  );
endinterface

// File: rtl/blink_sched.sv
// Round-robin scheduler sharing one LED pin and one tick prescaler among N_REQ requesters.
// Each grant runs a burst of cnt blinks with a half-period of per ticks, then pulses done.
module blink_sched #(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = 2_500_000,
  parameter int CNT_W    = 4,
  parameter int PER_W    = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  blink_sched_if.slave bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int IDX_W = $clog2(N_REQ);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic               led_q, led_d, busy_q, busy_d, tick_q, tick_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [PER_W-1:0]   per_q, per_d, tcnt_q, tcnt_d;
  logic [PW-1:0]      presc_q, presc_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  int                 cand;
  logic [CNT_W-1:0]   cnt_sel;
  logic [PER_W-1:0]   per_sel;
  logic               tick_now, phase_end;

  // Rotating search: first set request strictly after the last served index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_q) + 1 + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end

  assign cnt_sel   = bus.cnt_i[win*CNT_W +: CNT_W];
  assign per_sel   = bus.per_i[win*PER_W +: PER_W];
  assign tick_now  = (presc_q == PRESC_MAX);
  assign phase_end = tick_now && (tcnt_q == per_q - PER_W'(1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    led_d   = led_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    per_d   = per_q;
    tcnt_d  = tcnt_q;
    presc_d = '0;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        led_d  = 1'b0;
        if (found) begin
          idx_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          busy_d     = 1'b1;
          rem_d      = cnt_sel;
          per_d      = (per_sel == '0) ? PER_W'(1) : per_sel;
          tcnt_d     = '0;
          if (cnt_sel == '0) begin
            state_d     = DONE;
            done_d[win] = 1'b1;
          end else begin
            state_d = ON;
            led_d   = 1'b1;
          end
        end
      end
      ON, OFF: begin
        if (!bus.req_i[idx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          led_d   = 1'b0;
          busy_d  = 1'b0;
          ptr_d   = idx_q;
        end else begin
          presc_d = tick_now ? '0 : presc_q + PW'(1);
          if (tick_now) tcnt_d = tcnt_q + PER_W'(1);
          if (phase_end) begin
            tcnt_d = '0;
            if (state_q == ON) begin
              state_d = OFF;
              led_d   = 1'b0;
            end else begin
              rem_d = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d       = DONE;
                done_d[idx_q] = 1'b1;
              end else begin
                state_d = ON;
                led_d   = 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        led_d   = 1'b0;
        ptr_d   = idx_q;
      end
      default: state_d = IDLE;
    endcase
    // Tick is registered so it lines up with the cycle the prescaler sits at its top value.
    tick_d = ((state_d == ON) || (state_d == OFF)) && (presc_d == PRESC_MAX);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
      rem_q   <= '0;
      per_q   <= '0;
      tcnt_q  <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      tcnt_q  <= tcnt_d;
      presc_q <= presc_d;
    end
  end

  assign bus.gnt_o  = gnt_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = busy_q;
  assign bus.led_o  = led_q;
  assign bus.tick_o = tick_q;
  assign state_dbg  = state_q;

endmodule
